// File: rtl/sdram_pkg.sv
// -----------------------------------------------------------------------------
// sdram_pkg
// Shared types and constants for the SDRAM controller and its initiators.
//   sdram_cmd_t          : one controller command (word address, direction,
//                          auto-precharge request)
//   WRITE_CMD / READ_CMD : encodings of sdram_cmd_t.rw
//   burst_master_state_t : state encoding of sdram_burst_master
//   burst_align_mask()   : low address bits that must be zero for an address
//                          to sit on a burst boundary
// -----------------------------------------------------------------------------
package sdram_pkg;

   localparam int SDRAM_ADDR_WIDTH = 24;

   localparam logic WRITE_CMD = 1'b1;
   localparam logic READ_CMD  = 1'b0;

   typedef struct packed {
      logic [SDRAM_ADDR_WIDTH-1:0] addr;
      logic                        rw;
      logic                        auto_precharge_en;
   } sdram_cmd_t;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WRITE_DATA,
      READ_DATA,
      DONE
   } burst_master_state_t;

   // BURST_LEN is a power of two, so the misalignment bits are BURST_LEN-1.
   function automatic logic [SDRAM_ADDR_WIDTH-1:0] burst_align_mask(input int unsigned burst_len);
      return SDRAM_ADDR_WIDTH'(burst_len - 1);
   endfunction

endpackage

// File: rtl/sdram_burst_addr_gen.sv
// -----------------------------------------------------------------------------
// sdram_burst_addr_gen
// Address / burst / beat bookkeeping for sdram_burst_master.
//   clk, rstn     : clock, synchronous active-low reset
//   load          : capture load_addr and load_bursts for a new job
//   load_addr     : burst-aligned start word address
//   load_bursts   : number of bursts in the job
//   burst_start   : a command was accepted, rearm the beat counter
//   step          : one data beat transferred
//   next_addr     : address of the burst following the current one
//   last_beat     : current beat is the last of its burst
//   last_burst    : current burst is the last of the job
// -----------------------------------------------------------------------------
module sdram_burst_addr_gen #(
   parameter int ADDR_WIDTH = 24,
   parameter int BURST_LEN  = 8,
   parameter int MAX_BURSTS = 256
) (
   input  logic                               clk,
   input  logic                               rstn,
   input  logic                               load,
   input  logic [ADDR_WIDTH-1:0]              load_addr,
   input  logic [$clog2(MAX_BURSTS+1)-1:0]    load_bursts,
   input  logic                               burst_start,
   input  logic                               step,
   output logic [ADDR_WIDTH-1:0]              next_addr,
   output logic                               last_beat,
   output logic                               last_burst
);

   localparam int BW = $clog2(MAX_BURSTS+1);
   localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

   logic [ADDR_WIDTH-1:0] addr;
   logic [BW-1:0]         bursts_left;
   logic [CW-1:0]         beat_cnt;

   // The address wraps naturally at 2^ADDR_WIDTH.
   assign next_addr  = addr + ADDR_WIDTH'(BURST_LEN);
   assign last_beat  = (beat_cnt == '0);
   assign last_burst = (bursts_left == BW'(1));

   // beat_cnt counts down the remaining beats of the current burst; on the
   // last beat the burst is retired by advancing the address and the burst
   // count. The counter itself wraps back to BURST_LEN-1, although the next
   // command acceptance rearms it anyway.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         addr        <= '0;
         bursts_left <= '0;
         beat_cnt    <= '0;
      end else begin
         if (load) begin
            addr        <= load_addr;
            bursts_left <= load_bursts;
         end
         if (burst_start) begin
            beat_cnt <= CW'(BURST_LEN - 1);
         end else if (step) begin
            beat_cnt <= beat_cnt - 1'b1;
            if (beat_cnt == '0) begin
               addr        <= next_addr;
               bursts_left <= bursts_left - 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/sdram_burst_master.sv
// -----------------------------------------------------------------------------
// sdram_burst_master
// Turns one linear transfer job into a series of BURST_LEN-word commands for
// the SDRAM controller and streams the data words between the client and the
// controller.
//   clk, rstn                 : clock, synchronous active-low reset
//   job_valid/ready/write/
//   addr/bursts               : job request (start address must be
//                               BURST_LEN aligned, 1..MAX_BURSTS bursts)
//   job_done, job_error       : one-cycle completion / error pulses
//   busy                      : a job is in progress
//   cmd_valid/ready/data      : controller command port
//   wdata_valid/data/dqm/ready: controller write-data port
//   resp_valid/last/data/ready: controller read-response port
//   src_valid/data/ready      : write source stream
//   dst_valid/data/last/ready : read sink stream (sink must not stall)
// -----------------------------------------------------------------------------
module sdram_burst_master
   import sdram_pkg::*;
#(
   parameter int ADDR_WIDTH     = 24,
   parameter int DATA_WIDTH     = 16,
   parameter int BURST_LEN      = 8,
   parameter int MAX_BURSTS     = 256,
   parameter int AUTO_PRECHARGE = 1
) (
   input  logic                            clk,
   input  logic                            rstn,
   input  logic                            job_valid,
   output logic                            job_ready,
   input  logic                            job_write,
   input  logic [ADDR_WIDTH-1:0]           job_addr,
   input  logic [$clog2(MAX_BURSTS+1)-1:0] job_bursts,
   output logic                            job_done,
   output logic                            job_error,
   output logic                            busy,
   output logic                            cmd_valid,
   input  logic                            cmd_ready,
   output sdram_cmd_t                      cmd_data,
   output logic                            wdata_valid,
   output logic [DATA_WIDTH-1:0]           wdata,
   output logic [1:0]                      wdata_dqm,
   input  logic                            wdata_ready,
   input  logic                            resp_valid,
   input  logic                            resp_last,
   input  logic [DATA_WIDTH-1:0]           resp_data,
   output logic                            resp_ready,
   input  logic                            src_valid,
   input  logic [DATA_WIDTH-1:0]           src_data,
   output logic                            src_ready,
   output logic                            dst_valid,
   output logic [DATA_WIDTH-1:0]           dst_data,
   output logic                            dst_last,
   input  logic                            dst_ready
);

   localparam int                    BW           = $clog2(MAX_BURSTS+1);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK   = ADDR_WIDTH'(burst_align_mask(BURST_LEN));
   localparam logic [BW-1:0]         MAX_BURSTS_W = BW'(MAX_BURSTS);
   localparam logic                  AP_BIT       = (AUTO_PRECHARGE != 0);

   burst_master_state_t   state;
   logic                  job_ok;
   logic                  accept;
   logic                  burst_start;
   logic                  write_beat;
   logic                  read_beat;
   logic                  step;
   logic [ADDR_WIDTH-1:0] next_addr;
   logic                  last_beat;
   logic                  last_burst;

   // Job legality and the per-cycle transfer events that drive both the
   // FSM and the address generator.
   always_comb begin
      job_ok      = ((job_addr & ALIGN_MASK) == '0) &&
                    (job_bursts != '0) &&
                    (job_bursts <= MAX_BURSTS_W);
      accept      = (state == IDLE) && job_ready && job_valid && job_ok;
      burst_start = (state == ISSUE) && cmd_valid && cmd_ready;
      write_beat  = (state == WRITE_DATA) && src_valid && wdata_ready;
      read_beat   = (state == READ_DATA) && resp_valid;
      step        = write_beat || read_beat;
   end

   // Data paths are pure pass-through gated by the state so no latency is
   // added. Read beats are counted on resp_valid alone because the
   // controller cannot be back-pressured; the sink is required to keep
   // dst_ready high while reading.
   always_comb begin
      wdata_valid = (state == WRITE_DATA) && src_valid;
      wdata       = src_data;
      wdata_dqm   = 2'b00;
      src_ready   = (state == WRITE_DATA) && wdata_ready;
      dst_valid   = (state == READ_DATA) && resp_valid;
      dst_data    = resp_data;
      resp_ready  = (state == READ_DATA) && dst_ready;
      dst_last    = read_beat && last_beat && last_burst;
   end

   sdram_burst_addr_gen #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .BURST_LEN  (BURST_LEN),
      .MAX_BURSTS (MAX_BURSTS)
   ) u_addr_gen (
      .clk         (clk),
      .rstn        (rstn),
      .load        (accept),
      .load_addr   (job_addr),
      .load_bursts (job_bursts),
      .burst_start (burst_start),
      .step        (step),
      .next_addr   (next_addr),
      .last_beat   (last_beat),
      .last_burst  (last_burst)
   );

   // Job sequencing. cmd_data doubles as the latched job direction, and its
   // address is reloaded from the address generator's lookahead so the next
   // command is ready the same cycle ISSUE is re-entered. job_done and
   // job_error are single-cycle pulses cleared by default every cycle.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state     <= IDLE;
         job_ready <= 1'b0;
         busy      <= 1'b0;
         job_done  <= 1'b0;
         job_error <= 1'b0;
         cmd_valid <= 1'b0;
         cmd_data  <= '0;
      end else begin
         job_done  <= 1'b0;
         job_error <= 1'b0;
         case (state)
            IDLE: begin
               job_ready <= 1'b1;
               if (job_valid && job_ready) begin
                  if (!job_ok) begin
                     job_error <= 1'b1;
                  end else begin
                     job_ready <= 1'b0;
                     busy      <= 1'b1;
                     cmd_valid <= 1'b1;
                     cmd_data  <= '{addr:              SDRAM_ADDR_WIDTH'(job_addr),
                                    rw:                job_write ? WRITE_CMD : READ_CMD,
                                    auto_precharge_en: AP_BIT};
                     state     <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               if (cmd_ready) begin
                  cmd_valid <= 1'b0;
                  state     <= (cmd_data.rw == WRITE_CMD) ? WRITE_DATA : READ_DATA;
               end
            end
            WRITE_DATA: begin
               if (write_beat && last_beat) begin
                  if (last_burst) begin
                     job_done <= 1'b1;
                     state    <= DONE;
                  end else begin
                     cmd_valid     <= 1'b1;
                     cmd_data.addr <= SDRAM_ADDR_WIDTH'(next_addr);
                     state         <= ISSUE;
                  end
               end
            end
            READ_DATA: begin
               if (read_beat) begin
                  if (resp_last != last_beat) begin
                     job_error <= 1'b1;
                  end
                  if (last_beat) begin
                     if (last_burst) begin
                        job_done <= 1'b1;
                        state    <= DONE;
                     end else begin
                        cmd_valid     <= 1'b1;
                        cmd_data.addr <= SDRAM_ADDR_WIDTH'(next_addr);
                        state         <= ISSUE;
                     end
                  end
               end
            end
            DONE: begin
               busy      <= 1'b0;
               job_ready <= 1'b1;
               state     <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_burst_master.sv
// -----------------------------------------------------------------------------
// tb_sdram_burst_master
// Table of transfer jobs run against sdram_burst_master with a small
// controller/source/sink model, plus a hand-written mid-job reset sequence.
// -----------------------------------------------------------------------------
module tb_sdram_burst_master;
   import sdram_pkg::*;

   logic        clk;
   logic        rstn;
   logic        job_valid;
   logic        job_ready;
   logic        job_write;
   logic [23:0] job_addr;
   logic [8:0]  job_bursts;
   logic        job_done;
   logic        job_error;
   logic        busy;
   logic        cmd_valid;
   logic        cmd_ready;
   sdram_cmd_t  cmd_data;
   logic        wdata_valid;
   logic [15:0] wdata;
   logic [1:0]  wdata_dqm;
   logic        wdata_ready;
   logic        resp_valid;
   logic        resp_last;
   logic [15:0] resp_data;
   logic        resp_ready;
   logic        src_valid;
   logic [15:0] src_data;
   logic        src_ready;
   logic        dst_valid;
   logic [15:0] dst_data;
   logic        dst_last;
   logic        dst_ready;

   int n_vectors     = 0;
   int n_miscompares = 0;

   typedef struct {
      string       name;
      logic        wr;
      logic [23:0] addr;
      logic [8:0]  bursts;
      int          cmd_stall;
      bit          src_gaps;
      int          last_at;
      bit          poke_busy;
      bit          exp_reject;
      bit          exp_err;
      logic [15:0] src_base;
      logic [23:0] exp_a0;
      logic [23:0] exp_a1;
   } vec_t;

   vec_t vecs[8];

   sdram_burst_master dut (
      .clk         (clk),
      .rstn        (rstn),
      .job_valid   (job_valid),
      .job_ready   (job_ready),
      .job_write   (job_write),
      .job_addr    (job_addr),
      .job_bursts  (job_bursts),
      .job_done    (job_done),
      .job_error   (job_error),
      .busy        (busy),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_data    (cmd_data),
      .wdata_valid (wdata_valid),
      .wdata       (wdata),
      .wdata_dqm   (wdata_dqm),
      .wdata_ready (wdata_ready),
      .resp_valid  (resp_valid),
      .resp_last   (resp_last),
      .resp_data   (resp_data),
      .resp_ready  (resp_ready),
      .src_valid   (src_valid),
      .src_data    (src_data),
      .src_ready   (src_ready),
      .dst_valid   (dst_valid),
      .dst_data    (dst_data),
      .dst_last    (dst_last),
      .dst_ready   (dst_ready)
   );

   // 100 MHz clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Global time limit so the bench can never hang
   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_vectors++;
      if (actual !== expected) begin
         n_miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic idleInputs();
      job_valid   = 1'b0;
      job_write   = 1'b0;
      job_addr    = '0;
      job_bursts  = '0;
      cmd_ready   = 1'b0;
      wdata_ready = 1'b1;
      resp_valid  = 1'b0;
      resp_last   = 1'b0;
      resp_data   = '0;
      src_valid   = 1'b0;
      src_data    = '0;
      dst_ready   = 1'b1;
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "/job_ready"},   job_ready,   0);
      checkOutput({tag, "/busy"},        busy,        0);
      checkOutput({tag, "/job_done"},    job_done,    0);
      checkOutput({tag, "/job_error"},   job_error,   0);
      checkOutput({tag, "/cmd_valid"},   cmd_valid,   0);
      checkOutput({tag, "/cmd_data"},    cmd_data,    0);
      checkOutput({tag, "/wdata_valid"}, wdata_valid, 0);
      checkOutput({tag, "/wdata_dqm"},   wdata_dqm,   0);
      checkOutput({tag, "/resp_ready"},  resp_ready,  0);
      checkOutput({tag, "/src_ready"},   src_ready,   0);
      checkOutput({tag, "/dst_valid"},   dst_valid,   0);
      checkOutput({tag, "/dst_last"},    dst_last,    0);
   endtask

   // Runs one job with the controller, source and sink models and checks
   // every command, every data beat and the completion handshake.
   task automatic applyStimulus(input vec_t v);
      int          guard;
      int          cyc;
      int          stall;
      int          n_cmds;
      int          n_wr;
      int          n_rd;
      int          n_err;
      int          rsp_left;
      int          rsp_beat;
      int          last_beat_cyc;
      int          done_cyc;
      int          total;
      bit          done;
      bit          held;
      bit          toggle;
      logic [25:0] held_cmd;
      logic [23:0] rsp_addr;
      logic [23:0] ea;
      logic [15:0] exp_word;

      guard = 0;
      @(negedge clk);
      while (!job_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      checkOutput({v.name, "/job_ready_before"}, job_ready, 1);

      job_valid  = 1'b1;
      job_write  = v.wr;
      job_addr   = v.addr;
      job_bursts = v.bursts;
      @(negedge clk);
      job_valid = 1'b0;

      if (v.exp_reject) begin
         checkOutput({v.name, "/error_pulse"}, job_error, 1);
         checkOutput({v.name, "/busy"},        busy,      0);
         checkOutput({v.name, "/cmd_valid"},   cmd_valid, 0);
         @(negedge clk);
         checkOutput({v.name, "/error_end"},   job_error, 0);
         checkOutput({v.name, "/busy_after"},  busy,      0);
         checkOutput({v.name, "/cmd_after"},   cmd_valid, 0);
         checkOutput({v.name, "/ready_after"}, job_ready, 1);
         return;
      end

      checkOutput({v.name, "/busy"},      busy,      1);
      checkOutput({v.name, "/cmd_valid"}, cmd_valid, 1);
      checkOutput({v.name, "/job_ready"}, job_ready, 0);

      total         = int'(v.bursts) * 8;
      cyc           = 0;
      stall         = 0;
      n_cmds        = 0;
      n_wr          = 0;
      n_rd          = 0;
      n_err         = 0;
      rsp_left      = 0;
      rsp_beat      = 0;
      rsp_addr      = '0;
      last_beat_cyc = -1;
      done_cyc      = -1;
      done          = 1'b0;
      held          = 1'b0;
      held_cmd      = '0;
      toggle        = 1'b1;

      while (!done && cyc < 3000) begin
         // drive this cycle's inputs
         if (v.poke_busy) begin
            job_valid  = 1'b1;
            job_addr   = 24'h000003;
            job_bursts = 9'd1;
         end else begin
            job_valid = 1'b0;
         end
         cmd_ready   = cmd_valid && (stall >= v.cmd_stall);
         src_valid   = v.src_gaps ? toggle : 1'b1;
         toggle      = ~toggle;
         src_data    = v.src_base + 16'(n_wr);
         wdata_ready = 1'b1;
         dst_ready   = 1'b1;
         if (rsp_left > 0) begin
            resp_valid = 1'b1;
            resp_data  = rsp_addr[15:0] + 16'(rsp_beat);
            resp_last  = (rsp_beat + 1 == v.last_at);
         end else begin
            resp_valid = 1'b0;
            resp_last  = 1'b0;
            resp_data  = '0;
         end
         #1;

         // read beats leaving the DUT
         if (rsp_left > 0) begin
            ea       = (n_rd / 8 == 0) ? v.exp_a0 : v.exp_a1;
            exp_word = ea[15:0] + 16'(n_rd % 8);
            checkOutput({v.name, "/dst_valid"}, dst_valid, 1);
            checkOutput({v.name, "/dst_data"},  dst_data,  exp_word);
            checkOutput({v.name, "/dst_last"},  dst_last,  (n_rd == total - 1));
            n_rd++;
            rsp_beat++;
            rsp_left--;
            last_beat_cyc = cyc;
         end

         // write beats leaving the DUT
         if (src_valid && src_ready) begin
            checkOutput({v.name, "/wdata_valid"}, wdata_valid, 1);
            checkOutput({v.name, "/wdata"},       wdata,       v.src_base + 16'(n_wr));
            n_wr++;
            last_beat_cyc = cyc;
         end else if (src_valid) begin
            checkOutput({v.name, "/wdata_gated"}, wdata_valid, 0);
         end

         // controller command port
         if (cmd_valid) begin
            if (held) begin
               checkOutput({v.name, "/cmd_hold"}, cmd_data, held_cmd);
            end
            if (cmd_ready) begin
               ea = (n_cmds == 0) ? v.exp_a0 : v.exp_a1;
               checkOutput({v.name, "/cmd_addr"}, cmd_data.addr, ea);
               checkOutput({v.name, "/cmd_rw"},   cmd_data.rw, v.wr);
               checkOutput({v.name, "/cmd_ap"},   cmd_data.auto_precharge_en, 1);
               checkOutput({v.name, "/beats_before_cmd"}, (v.wr ? n_wr : n_rd), n_cmds * 8);
               n_cmds++;
               if (!v.wr) begin
                  rsp_left = 8;
                  rsp_beat = 0;
                  rsp_addr = cmd_data.addr;
               end
               held  = 1'b0;
               stall = 0;
            end else begin
               held     = 1'b1;
               held_cmd = cmd_data;
               stall++;
            end
         end

         if (job_error) n_err++;
         if (job_done) begin
            done     = 1'b1;
            done_cyc = cyc;
         end

         @(negedge clk);
         cyc++;
      end

      idleInputs();
      #1;
      checkOutput({v.name, "/done_seen"},    done,   1);
      checkOutput({v.name, "/cmd_count"},    n_cmds, int'(v.bursts));
      checkOutput({v.name, "/beat_count"},   (v.wr ? n_wr : n_rd), total);
      checkOutput({v.name, "/done_latency"}, done_cyc, last_beat_cyc + 1);
      if (v.exp_err) begin
         checkOutput({v.name, "/error_seen"}, (n_err > 0), 1);
      end else begin
         checkOutput({v.name, "/error_count"}, n_err, 0);
      end
      checkOutput({v.name, "/done_pulse_end"}, job_done,  0);
      checkOutput({v.name, "/ready_after"},    job_ready, 1);
      checkOutput({v.name, "/busy_after"},     busy,      0);
   endtask

   initial begin
      vec_t after_rst;

      //              name             wr    addr          bursts stall gaps last poke rej   err   src_base  exp_a0        exp_a1
      vecs[0] = '{"wr_basic",      1'b1, 24'h000100, 9'd2,   0, 1'b0, 8, 1'b0, 1'b0, 1'b0, 16'h0000, 24'h000100, 24'h000108};
      vecs[1] = '{"rd_bank_cross", 1'b0, 24'h3FFFF8, 9'd2,   0, 1'b0, 8, 1'b0, 1'b0, 1'b0, 16'h0000, 24'h3FFFF8, 24'h400000};
      vecs[2] = '{"rej_unaligned", 1'b1, 24'h000103, 9'd2,   0, 1'b0, 8, 1'b0, 1'b1, 1'b0, 16'h0000, 24'h000000, 24'h000000};
      vecs[3] = '{"rej_zero",      1'b0, 24'h000100, 9'd0,   0, 1'b0, 8, 1'b0, 1'b1, 1'b0, 16'h0000, 24'h000000, 24'h000000};
      vecs[4] = '{"wr_stall",      1'b1, 24'h000200, 9'd2,   5, 1'b1, 8, 1'b0, 1'b0, 1'b0, 16'hA000, 24'h000200, 24'h000208};
      vecs[5] = '{"rd_early_last", 1'b0, 24'h000040, 9'd1,   0, 1'b0, 7, 1'b0, 1'b0, 1'b1, 16'h0000, 24'h000040, 24'h000000};
      vecs[6] = '{"rej_too_many",  1'b1, 24'h000100, 9'd257, 0, 1'b0, 8, 1'b0, 1'b1, 1'b0, 16'h0000, 24'h000000, 24'h000000};
      vecs[7] = '{"rd_wrap_busy",  1'b0, 24'hFFFFF8, 9'd2,   2, 1'b0, 8, 1'b1, 1'b0, 1'b0, 16'h0000, 24'hFFFFF8, 24'h000000};

      idleInputs();
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checkResetOutputs("reset");
      rstn = 1'b1;

      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i]);
      end

      // Mid-job reset: start a one-burst write, assert rstn during beat 4.
      @(negedge clk);
      while (!job_ready) @(negedge clk);
      job_valid  = 1'b1;
      job_write  = 1'b1;
      job_addr   = 24'h000300;
      job_bursts = 9'd1;
      @(negedge clk);
      job_valid = 1'b0;
      cmd_ready = 1'b1;
      @(negedge clk);
      cmd_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         src_valid = 1'b1;
         src_data  = 16'(i);
         #1;
         checkOutput("midrst/beat_ready", src_ready, 1);
         @(negedge clk);
      end
      src_valid = 1'b1;
      src_data  = 16'h0003;
      resp_valid = 1'b1;
      rstn      = 1'b0;
      @(negedge clk);
      #1;
      checkResetOutputs("midrst");
      rstn = 1'b1;
      idleInputs();
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         #1;
         if (job_done) begin
            checkOutput("midrst/no_done", job_done, 0);
         end
      end
      checkOutput("midrst/idle_busy", busy, 0);

      after_rst = '{"after_reset", 1'b1, 24'h000400, 9'd1, 1, 1'b0, 8, 1'b0, 1'b0, 1'b0,
                    16'h5500, 24'h000400, 24'h000000};
      applyStimulus(after_rst);

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end

endmodule
